// File: rtl/gerenciador_reservatorio_rolhas_pkg.sv
// Shared constants for the cork-reservoir manager: FSM encodings, default
// capacities/thresholds and the lot-size helper.
package pkg_rolhas;

   localparam logic [1:0] IDLE     = 2'b00;
   localparam logic [1:0] TRANSFER = 2'b01;
   localparam logic [1:0] REFILL   = 2'b10;

   localparam int unsigned DEF_WIDTH           = 7;
   localparam int unsigned DEF_CAP_PRINCIPAL   = 99;
   localparam int unsigned DEF_CAP_SECUNDARIO  = 99;
   localparam int unsigned DEF_MIN_PRINCIPAL   = 5;
   localparam int unsigned DEF_LOTE_TRANSF     = 15;
   localparam int unsigned DEF_INIT_PRINCIPAL  = 0;
   localparam int unsigned DEF_INIT_SECUNDARIO = 20;

   function automatic int unsigned min3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/gerenciador_reservatorio_rolhas_contador.sv
// Up/down counter with parallel load; simultaneous inc and dec hold the value.
module contador_updown_param #(
   parameter int unsigned      WIDTH = 7,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (inc_i && !dec_i)
         count_d = count_q + 1'b1;
      else if (dec_i && !inc_i)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= INIT;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/gerenciador_reservatorio_rolhas.sv
// Cork-reservoir manager: primary/secondary counts, automatic lot transfer,
// queued operator refills with overflow rejection, concurrent consumption.
module gerenciador_reservatorio_rolhas
   import pkg_rolhas::*;
#(
   parameter int unsigned WIDTH           = DEF_WIDTH,
   parameter int unsigned CAP_PRINCIPAL   = DEF_CAP_PRINCIPAL,
   parameter int unsigned CAP_SECUNDARIO  = DEF_CAP_SECUNDARIO,
   parameter int unsigned MIN_PRINCIPAL   = DEF_MIN_PRINCIPAL,
   parameter int unsigned LOTE_TRANSF     = DEF_LOTE_TRANSF,
   parameter int unsigned INIT_PRINCIPAL  = DEF_INIT_PRINCIPAL,
   parameter int unsigned INIT_SECUNDARIO = DEF_INIT_SECUNDARIO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             consumo,
   input  logic             refill_req,
   input  logic [WIDTH-1:0] refill_qty,
   output logic [WIDTH-1:0] principal,
   output logic [WIDTH-1:0] secundario,
   output logic             transferindo,
   output logic             ro,
   output logic             baixo,
   output logic             refill_ack,
   output logic             refill_err,
   output logic             consumo_negado,
   output logic [1:0]       estado
);

   localparam logic [WIDTH:0] CAP_SEC_EXT = (WIDTH+1)'(CAP_SECUNDARIO);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] restante_q, restante_d;
   logic [WIDTH-1:0] qty_q, qty_d;
   logic             pending_q, pending_d;
   logic             ack_q, ack_d, err_q, err_d, negado_q, negado_d;

   logic             passo, pode_consumir, p_dec, cabe;
   logic [WIDTH:0]   soma;
   logic [WIDTH-1:0] lote;

   assign passo = (state_q == TRANSFER) && enable;
   assign soma  = {1'b0, secundario} + {1'b0, qty_q};
   assign cabe  = (soma <= CAP_SEC_EXT);
   assign lote  = WIDTH'(min3(LOTE_TRANSF, 32'(secundario),
                              CAP_PRINCIPAL - 32'(principal)));

   // A transfer cork arriving this cycle makes a consume from an empty primary legal.
   assign pode_consumir = (principal != '0) || passo;
   assign p_dec         = consumo && pode_consumir;
   assign negado_d      = consumo && !pode_consumir;

   contador_updown_param #(
      .WIDTH (WIDTH),
      .INIT  (WIDTH'(INIT_PRINCIPAL))
   ) u_principal (
      .clk        (clk),
      .rst        (rst),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (passo),
      .dec_i      (p_dec),
      .count_o    (principal)
   );

   contador_updown_param #(
      .WIDTH (WIDTH),
      .INIT  (WIDTH'(INIT_SECUNDARIO))
   ) u_secundario (
      .clk        (clk),
      .rst        (rst),
      .load_i     ((state_q == REFILL) && cabe),
      .load_val_i (soma[WIDTH-1:0]),
      .inc_i      (1'b0),
      .dec_i      (passo),
      .count_o    (secundario)
   );

   always_comb begin
      state_d    = state_q;
      restante_d = restante_q;
      pending_d  = pending_q;
      qty_d      = qty_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q || refill_req) begin
               state_d = REFILL;
               if (refill_req) qty_d = refill_qty;
            end else if (enable && baixo && (secundario != '0)) begin
               state_d    = TRANSFER;
               restante_d = lote;
            end
         end
         TRANSFER: begin
            if (refill_req) begin
               qty_d     = refill_qty;
               pending_d = 1'b1;
            end
            if (enable) begin
               restante_d = restante_q - 1'b1;
               if (restante_q == WIDTH'(1)) state_d = IDLE;
            end
         end
         REFILL: begin
            ack_d     = cabe;
            err_d     = !cabe;
            pending_d = 1'b0;
            state_d   = IDLE;
            if (refill_req) begin
               qty_d     = refill_qty;
               pending_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         restante_q <= '0;
         pending_q  <= 1'b0;
         qty_q      <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         negado_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         restante_q <= restante_d;
         pending_q  <= pending_d;
         qty_q      <= qty_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         negado_q   <= negado_d;
      end
   end

   assign transferindo   = (state_q == TRANSFER);
   assign ro             = (principal == '0);
   assign baixo          = (principal < WIDTH'(MIN_PRINCIPAL));
   assign refill_ack     = ack_q;
   assign refill_err     = err_q;
   assign consumo_negado = negado_q;
   assign estado         = state_q;

endmodule
